// File: rtl/boron_pkg.sv
// Shared constants, state encodings and index helpers for the BORON round-key reader.
package boron_pkg;

    localparam int KEY_W     = 80;
    localparam int NUM_SLOTS = 26;
    localparam int IDX_W     = 5;
    localparam int STORE_W   = KEY_W * NUM_SLOTS;

    localparam logic [IDX_W-1:0] FIRST_ROUND = 5'd0;
    localparam logic [IDX_W-1:0] LAST_ROUND  = 5'd25;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOADED = 2'd1,
        STREAM = 2'd2
    } state_t;

    // Encrypt walks K0 upward, decrypt walks K25 downward.
    function automatic logic [IDX_W-1:0] first_index(input logic mode);
        return (mode == MODE_DEC) ? LAST_ROUND : FIRST_ROUND;
    endfunction

    function automatic logic is_last(input logic [IDX_W-1:0] idx, input logic dir);
        return (dir == MODE_DEC) ? (idx == FIRST_ROUND) : (idx == LAST_ROUND);
    endfunction

endpackage

// File: rtl/round_key_reader_if.sv
// Round-key stream towards the round engine: key, slot index and valid/ready handshake.
interface round_key_reader_if;
    import boron_pkg::*;

    logic [KEY_W-1:0] rk_out;
    logic [IDX_W-1:0] rk_index;
    logic             rk_valid;
    logic             rk_ready;

    modport master (
        output rk_out,
        output rk_index,
        output rk_valid,
        input  rk_ready
    );

    modport slave (
        input  rk_out,
        input  rk_index,
        input  rk_valid,
        output rk_ready
    );

endinterface

// File: rtl/boron_key_slot_mux.sv
// Combinational 26:1 select of one KEY_W-wide slot out of the packed key store.
module boron_key_slot_mux
    import boron_pkg::*;
(
    input  logic [STORE_W-1:0] store,
    input  logic [IDX_W-1:0]   idx,
    output logic [KEY_W-1:0]   slot
);

    logic [KEY_W-1:0] slots [NUM_SLOTS];

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign slots[gi] = store[gi*KEY_W +: KEY_W];
    end

    // Indices 26..31 never occur in a stream; they select zero.
    always_comb begin
        slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx == IDX_W'(i)) begin
                slot = slots[i];
            end
        end
    end

endmodule

// File: rtl/round_key_reader.sv
// Captures the packed key schedule and streams K0..K25 (or K25..K0) over valid/ready.
module round_key_reader
    import boron_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [STORE_W-1:0]  key_register,
    input  logic                load,
    input  logic                mode,
    input  logic                start,
    input  logic                abort,
    round_key_reader_if.master  rk,
    output logic                keys_loaded,
    output logic                busy,
    output logic                done
);

    state_t             state_q, state_d;
    logic [STORE_W-1:0] store_q, store_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dir_q, dir_d;
    logic [KEY_W-1:0]   rk_out_q, rk_out_d;
    logic               rk_valid_q, rk_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               keys_loaded_q, keys_loaded_d;

    logic [KEY_W-1:0]   slot_next;
    logic               xfer;
    logic               last;
    logic               begin_stream;
    logic               can_load;

    assign xfer         = rk_valid_q & rk.rk_ready;
    assign last         = is_last(idx_q, dir_q);
    assign can_load     = load & (state_q != STREAM);
    // load takes priority over start when both arrive in LOADED
    assign begin_stream = (state_q == LOADED) & start & ~load;

    // The slot for the index being registered this edge, so rk_out and rk_index move together.
    boron_key_slot_mux u_slot_mux (
        .store (store_q),
        .idx   (idx_d),
        .slot  (slot_next)
    );

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q       <= EMPTY;
            store_q       <= '0;
            idx_q         <= '0;
            dir_q         <= MODE_ENC;
            rk_out_q      <= '0;
            rk_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            keys_loaded_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            idx_q         <= idx_d;
            dir_q         <= dir_d;
            rk_out_q      <= rk_out_d;
            rk_valid_q    <= rk_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            keys_loaded_q <= keys_loaded_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load) state_d = LOADED;
            LOADED:  if (begin_stream) state_d = STREAM;
            STREAM:  if (abort || (xfer && last)) state_d = LOADED;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        dir_d = dir_q;
        if (begin_stream) begin
            idx_d = first_index(mode);
            dir_d = mode;
        end else if ((state_q == STREAM) && !abort && xfer && !last) begin
            idx_d = (dir_q == MODE_DEC) ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        store_d       = store_q;
        keys_loaded_d = keys_loaded_q;
        rk_out_d      = rk_out_q;
        rk_valid_d    = rk_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        if (can_load) begin
            store_d       = key_register;
            keys_loaded_d = 1'b1;
        end

        if (begin_stream) begin
            rk_out_d   = slot_next;
            rk_valid_d = 1'b1;
            busy_d     = 1'b1;
        end

        if (state_q == STREAM) begin
            if (abort) begin
                rk_valid_d = 1'b0;
                busy_d     = 1'b0;
            end else if (xfer) begin
                if (last) begin
                    rk_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    rk_out_d = slot_next;
                end
            end
        end
    end

    assign rk.rk_out    = rk_out_q;
    assign rk.rk_index  = idx_q;
    assign rk.rk_valid  = rk_valid_q;
    assign keys_loaded  = keys_loaded_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_round_key_reader.sv
// Self-checking bench for round_key_reader: control table plus scoreboarded key streams.
module tb_round_key_reader;
    import boron_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [STORE_W-1:0] key_register;
    logic               load, mode, start, abort;
    logic               keys_loaded, busy, done;

    round_key_reader_if rk_if ();

    round_key_reader dut (
        .clk          (clk),
        .reset        (reset),
        .key_register (key_register),
        .load         (load),
        .mode         (mode),
        .start        (start),
        .abort        (abort),
        .rk           (rk_if),
        .keys_loaded  (keys_loaded),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int done_seen  = 0;

    typedef struct {
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] idx;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic             load;
        logic             start;
        logic             mode;
        logic             abort;
        logic             chk_rk;
        logic [KEY_W-1:0] exp_rk;
        logic [IDX_W-1:0] exp_idx;
        logic             exp_valid;
        logic             exp_busy;
        logic             exp_loaded;
    } vec_t;
    vec_t tbl[9];

    task automatic check_key(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the design acts on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [STORE_W-1:0] build_keys(input int base);
        logic [STORE_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            r[i*KEY_W +: KEY_W] = KEY_W'(base + i);
        end
        return r;
    endfunction

    task automatic push_stream(input int base, input logic m);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            exp_t e;
            e.idx = (m == MODE_DEC) ? IDX_W'(25 - i) : IDX_W'(i);
            e.key = KEY_W'(base) + KEY_W'(e.idx);
            sb.push_back(e);
        end
    endtask

    task automatic run_until_idle(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 100) begin
            cyc();
            n++;
        end
        check_int(name, n, exp_cycles);
    endtask

    task automatic wait_index(input string name, input int target);
        int n = 0;
        while ((int'(rk_if.rk_index) != target || !rk_if.rk_valid) && n < 60) begin
            cyc();
            n++;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $display("FAIL %s: index %0d never reached, last index %0d", name, target, rk_if.rk_index);
        end
    endtask

    task automatic begin_stream(input logic m);
        mode           = m;
        start          = 1'b1;
        rk_if.rk_ready = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Monitor: inputs for the coming falling edge are settled, so a transfer is known here.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (done === 1'b1) done_seen++;
            if (rk_if.rk_valid && rk_if.rk_ready && !abort && !reset) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got key %0d idx %0d, expected no transfer",
                             rk_if.rk_out, rk_if.rk_index);
                end else begin
                    e = sb.pop_front();
                    $display("xfer idx=%0d key=%0d exp_idx=%0d exp_key=%0d",
                             rk_if.rk_index, rk_if.rk_out, e.idx, e.key);
                    check_key("sb_key", rk_if.rk_out, e.key);
                    check_int("sb_idx", int'(rk_if.rk_index), int'(e.idx));
                end
            end
        end
    end

    initial begin
        int d0;

        reset          = 1'b1;
        load           = 1'b0;
        mode           = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        rk_if.rk_ready = 1'b0;
        key_register   = build_keys(1000);

        // load/start/mode/abort | chk_rk, rk, idx | valid, busy, keys_loaded
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 80'd0,    5'd0,  1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 80'd0,    5'd0,  1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 80'd0,    5'd0,  1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 80'd0,    5'd0,  1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 80'd1000, 5'd0,  1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 80'd0,    5'd0,  1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 80'd1025, 5'd25, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 80'd1025, 5'd25, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 80'd0,    5'd0,  1'b0, 1'b0, 1'b1};

        cyc();
        cyc();
        check_key("reset_rk_out", rk_if.rk_out, '0);
        check_int("reset_rk_index", int'(rk_if.rk_index), 0);
        check_bit("reset_rk_valid", rk_if.rk_valid, 1'b0);
        check_bit("reset_keys_loaded", keys_loaded, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        reset = 1'b0;

        // Control table: start without load, load+start collision, abort, mode change mid-stream.
        for (int r = 0; r < 9; r++) begin
            load  = tbl[r].load;
            start = tbl[r].start;
            mode  = tbl[r].mode;
            abort = tbl[r].abort;
            cyc();
            $display("row %0d valid=%b busy=%b loaded=%b idx=%0d rk=%0d",
                     r, rk_if.rk_valid, busy, keys_loaded, rk_if.rk_index, rk_if.rk_out);
            check_bit($sformatf("row%0d_valid", r), rk_if.rk_valid, tbl[r].exp_valid);
            check_bit($sformatf("row%0d_busy", r), busy, tbl[r].exp_busy);
            check_bit($sformatf("row%0d_loaded", r), keys_loaded, tbl[r].exp_loaded);
            check_bit($sformatf("row%0d_done", r), done, 1'b0);
            if (tbl[r].chk_rk) begin
                check_key($sformatf("row%0d_rk", r), rk_if.rk_out, tbl[r].exp_rk);
                check_int($sformatf("row%0d_idx", r), int'(rk_if.rk_index), int'(tbl[r].exp_idx));
            end
        end
        load  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 1'b0;
        cyc();

        // Encrypt stream, back-to-back.
        d0 = done_seen;
        push_stream(1000, MODE_ENC);
        begin_stream(MODE_ENC);
        check_key("enc_first_key", rk_if.rk_out, 80'd1000);
        run_until_idle("enc_len", 26);
        check_bit("enc_done_high", done, 1'b1);
        cyc();
        check_bit("enc_done_low", done, 1'b0);
        check_bit("enc_busy_low", busy, 1'b0);
        check_int("enc_done_count", done_seen - d0, 1);
        check_int("enc_sb_empty", sb.size(), 0);

        // Decrypt stream on the same store.
        d0 = done_seen;
        push_stream(1000, MODE_DEC);
        begin_stream(MODE_DEC);
        check_key("dec_first_key", rk_if.rk_out, 80'd1025);
        check_int("dec_first_idx", int'(rk_if.rk_index), 25);
        run_until_idle("dec_len", 26);
        cyc();
        check_int("dec_done_count", done_seen - d0, 1);
        check_int("dec_sb_empty", sb.size(), 0);

        // Back-pressure at index 7.
        push_stream(1000, MODE_ENC);
        begin_stream(MODE_ENC);
        wait_index("stall_reach7", 7);
        rk_if.rk_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_key($sformatf("stall%0d_key", k), rk_if.rk_out, 80'd1007);
            check_int($sformatf("stall%0d_idx", k), int'(rk_if.rk_index), 7);
            check_bit($sformatf("stall%0d_valid", k), rk_if.rk_valid, 1'b1);
        end
        rk_if.rk_ready = 1'b1;
        run_until_idle("stall_tail_len", 19);
        cyc();
        check_int("stall_sb_empty", sb.size(), 0);

        // Abort at index 12 with ready high: abort wins, no done.
        d0 = done_seen;
        push_stream(1000, MODE_ENC);
        begin_stream(MODE_ENC);
        wait_index("abort_reach12", 12);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_bit("abort_valid", rk_if.rk_valid, 1'b0);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check_int("abort_remaining", sb.size(), 14);
        sb.delete();
        cyc();
        check_int("abort_no_done", done_seen - d0, 0);
        push_stream(1000, MODE_ENC);
        begin_stream(MODE_ENC);
        check_key("restart_first_key", rk_if.rk_out, 80'd1000);
        check_int("restart_first_idx", int'(rk_if.rk_index), 0);
        run_until_idle("restart_len", 26);
        cyc();
        check_int("restart_sb_empty", sb.size(), 0);

        // Load mid-stream is ignored; reset at index 20 clears everything.
        push_stream(1000, MODE_ENC);
        begin_stream(MODE_ENC);
        wait_index("midload_reach5", 5);
        key_register = build_keys(2000);
        load = 1'b1;
        cyc();
        load = 1'b0;
        wait_index("midreset_reach20", 20);
        reset = 1'b1;
        cyc();
        check_key("midreset_rk_out", rk_if.rk_out, '0);
        check_int("midreset_idx", int'(rk_if.rk_index), 0);
        check_bit("midreset_valid", rk_if.rk_valid, 1'b0);
        check_bit("midreset_loaded", keys_loaded, 1'b0);
        check_bit("midreset_busy", busy, 1'b0);
        check_bit("midreset_done", done, 1'b0);
        reset = 1'b0;
        sb.delete();
        begin_stream(MODE_ENC);
        check_bit("postreset_start_valid", rk_if.rk_valid, 1'b0);
        check_bit("postreset_start_busy", busy, 1'b0);
        rk_if.rk_ready = 1'b0;
        load = 1'b1;
        cyc();
        load = 1'b0;
        check_bit("reload_loaded", keys_loaded, 1'b1);
        mode  = MODE_DEC;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_key("reload_first_key", rk_if.rk_out, 80'd2025);
        check_int("reload_first_idx", int'(rk_if.rk_index), 25);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_bit("reload_abort_valid", rk_if.rk_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
